// File: rtl/uart_buffer_router.sv
// Multi-channel UART store-and-forward router over one shared single-port RAM.
// Optional overflow-drop mode is enabled by defining UART_BUFFER_ROUTER_OVF_EN.
module uart_buffer_router #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int AW_CH = 4,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NCH-1:0]        i_rx_ready,
    input  logic [NCH*DW-1:0]     i_rx_data,
    output logic [NCH-1:0]        o_rx_read,
    input  logic [NCH-1:0]        i_tx_busy,
    output logic [NCH-1:0]        o_tx_write,
    output logic [DW-1:0]         o_tx_data,
    output logic [CW+AW_CH-1:0]   o_addr,
    output logic [DW-1:0]         o_wdata,
    input  logic [DW-1:0]         i_rdata,
    output logic                  o_we,
    output logic                  o_re,
    output logic [NCH-1:0]        o_empty,
    output logic [NCH-1:0]        o_ovf,
    input  logic [NCH-1:0]        i_ovf_clr
);

    typedef enum logic {RECV, SEND} state_t;

    localparam logic [AW_CH:0] FULL_LVL = {1'b1, {AW_CH{1'b0}}};

    state_t           state, state_next;
    logic [AW_CH:0]   wr_ptr [NCH];
    logic [AW_CH:0]   rd_ptr [NCH];
    logic [CW-1:0]    rr_rx, rr_tx, pend_ch;
    logic             pend_v;
    logic [NCH-1:0]   full, empty, rx_elig, tx_elig;
    logic             rx_gnt_v, tx_gnt_v, rx_store;
    logic [CW-1:0]    rx_gnt, tx_gnt;

    // Returns {valid, index} of the first set bit at or above start, wrapping.
    function automatic logic [CW:0] pick(input logic [NCH-1:0] elig, input logic [CW-1:0] start);
        int idx;
        pick = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NCH;
            if (elig[idx]) pick = {1'b1, CW'(idx)};
        end
    endfunction

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] g);
        next_idx = (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < NCH; i++) begin
            full[i]  = (wr_ptr[i] - rd_ptr[i]) == FULL_LVL;
            empty[i] = wr_ptr[i] == rd_ptr[i];
        end
    end

`ifdef UART_BUFFER_ROUTER_OVF_EN
    assign rx_elig = i_rx_ready;
`else
    assign rx_elig = i_rx_ready & ~full;
`endif
    assign tx_elig = ~empty & ~i_tx_busy;

    assign {rx_gnt_v, rx_gnt} = (state == RECV) ? pick(rx_elig, rr_rx) : '0;
    assign {tx_gnt_v, tx_gnt} = (state == SEND) ? pick(tx_elig, rr_tx) : '0;
    // A granted full channel only happens in overflow mode: the byte is popped and dropped.
    assign rx_store = rx_gnt_v && !full[rx_gnt];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= RECV;
        else        state <= state_next;
    end

    always_comb begin
        state_next = (state == RECV) ? SEND : RECV;
    end

    always_comb begin
        o_rx_read  = '0;
        o_tx_write = '0;
        o_we       = 1'b0;
        o_re       = 1'b0;
        o_addr     = '0;
        o_wdata    = '0;
        o_tx_data  = '0;
        if (rx_gnt_v) begin
            o_rx_read[rx_gnt] = 1'b1;
            if (rx_store) begin
                o_we    = 1'b1;
                o_addr  = {rx_gnt, wr_ptr[rx_gnt][AW_CH-1:0]};
                o_wdata = i_rx_data[rx_gnt*DW +: DW];
            end
        end
        if (state == RECV && pend_v) begin
            o_tx_write[pend_ch] = 1'b1;
            o_tx_data           = i_rdata;
        end
        if (tx_gnt_v) begin
            o_re   = 1'b1;
            o_addr = {tx_gnt, rd_ptr[tx_gnt][AW_CH-1:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_rx   <= '0;
            rr_tx   <= '0;
            pend_ch <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (rx_gnt_v) rr_rx <= next_idx(rx_gnt);
            if (rx_store) wr_ptr[rx_gnt] <= wr_ptr[rx_gnt] + 1'b1;
            if (tx_gnt_v) begin
                rd_ptr[tx_gnt] <= rd_ptr[tx_gnt] + 1'b1;
                rr_tx          <= next_idx(tx_gnt);
                pend_ch        <= tx_gnt;
            end
            pend_v <= tx_gnt_v;
        end
    end

    assign o_empty = empty;

`ifdef UART_BUFFER_ROUTER_OVF_EN
    logic [NCH-1:0] ovf, ovf_set;

    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NCH; i++)
            ovf_set[i] = rx_gnt_v && !rx_store && (rx_gnt == CW'(i));
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) ovf <= '0;
        else        ovf <= (ovf & ~i_ovf_clr) | ovf_set;
    end

    assign o_ovf = ovf;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^i_ovf_clr;
    assign o_ovf = '0;
`endif

endmodule

// File: tb/tb_uart_buffer_router.sv
// Directed testbench for uart_buffer_router: vector table plus fill, wrap and reset sequences.
// Define UART_BUFFER_ROUTER_OVF_EN to exercise the overflow-drop mode.
module tb_uart_buffer_router;

    localparam int NCH = 4, DW = 8, AW_CH = 4, AW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  rx_ready, rx_read, tx_busy, tx_write, empty, ovf, ovf_clr;
    logic [NCH*DW-1:0] rx_data;
    logic [DW-1:0]   tx_data, wdata, rdata;
    logic [AW-1:0]   addr;
    logic            we, re;
    logic            tb_recv;
    logic [DW-1:0]   mem [64];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_buffer_router #(.NCH(NCH), .DW(DW), .AW_CH(AW_CH)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_rx_ready(rx_ready), .i_rx_data(rx_data), .o_rx_read(rx_read),
        .i_tx_busy(tx_busy), .o_tx_write(tx_write), .o_tx_data(tx_data),
        .o_addr(addr), .o_wdata(wdata), .i_rdata(rdata),
        .o_we(we), .o_re(re), .o_empty(empty), .o_ovf(ovf), .i_ovf_clr(ovf_clr)
    );

    // Board RAM with one-cycle read latency
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

    // Independent phase model: RECV out of reset, then alternate
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_recv <= 1'b1;
        else        tb_recv <= ~tb_recv;
    end

    typedef struct packed {
        logic [3:0]  rx_ready;
        logic [31:0] rx_data;
        logic [3:0]  tx_busy;
        logic [3:0]  rx_read;
        logic        we;
        logic        re;
        logic [3:0]  tx_write;
        logic [5:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  tx_data;
        logic [3:0]  empty;
    } vec_t;

    vec_t vecs [13];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] rdy, input logic [31:0] dat, input logic [3:0] busy);
        rx_ready = rdy;
        rx_data  = dat;
        tx_busy  = busy;
    endtask

    // Returns at posedge+1 with reset released and the block in its first RECV cycle
    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(4'h0, 32'h0, 4'h0);
        ovf_clr = 4'h0;
        @(posedge clk); #3;
        check_output("reset_state", {rx_read, tx_write, we, re, addr, wdata, tx_data, empty, ovf},
                     {32'h0, 4'hF, 4'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int reads, writes, exp_ch, sent, got, loads, busy_cnt, n, late_tx;
        int cnt [4];
        logic [3:0] exp_rd;

        apply_stimulus(4'h0, 32'h0, 4'h0);
        ovf_clr = 4'h0;

        vecs[0]  = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h00, 8'h00, 8'h00, 4'hF};
        vecs[1]  = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h00, 8'h00, 8'h00, 4'hF};
        vecs[2]  = {4'h4, 32'h00A50000, 4'h0, 4'h4, 1'b1, 1'b0, 4'h0, 6'h20, 8'hA5, 8'h00, 4'hF};
        vecs[3]  = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 6'h20, 8'h00, 8'h00, 4'hB};
        vecs[4]  = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 6'h00, 8'h00, 8'hA5, 4'hF};
        vecs[5]  = {4'h1, 32'h00000011, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 6'h00, 8'h00, 8'h00, 4'hF};
        vecs[6]  = {4'h9, 32'h33000011, 4'h4, 4'h8, 1'b1, 1'b0, 4'h0, 6'h30, 8'h33, 8'h00, 4'hF};
        vecs[7]  = {4'h1, 32'h00000011, 4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 6'h00, 8'h00, 8'h00, 4'h7};
        vecs[8]  = {4'h1, 32'h00000011, 4'h8, 4'h1, 1'b1, 1'b0, 4'h0, 6'h00, 8'h11, 8'h00, 4'h7};
        vecs[9]  = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 6'h30, 8'h00, 8'h00, 4'h6};
        vecs[10] = {4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 4'h8, 6'h00, 8'h00, 8'h33, 4'hE};
        vecs[11] = {4'h0, 32'h0,        4'h8, 4'h0, 1'b0, 1'b1, 4'h0, 6'h00, 8'h00, 8'h00, 4'hE};
        vecs[12] = {4'h0, 32'h0,        4'h8, 4'h0, 1'b0, 1'b0, 4'h1, 6'h00, 8'h00, 8'h11, 4'hF};

        // Vector table: idle, single byte on ch2, round-robin and busy handling
        do_reset();
        for (int v = 0; v < 13; v++) begin
            apply_stimulus(vecs[v].rx_ready, vecs[v].rx_data, vecs[v].tx_busy);
            @(negedge clk);
            check_output($sformatf("vec%0d", v),
                         {rx_read, we, re, tx_write, addr, wdata, tx_data, empty},
                         {vecs[v].rx_read, vecs[v].we, vecs[v].re, vecs[v].tx_write,
                          vecs[v].addr, vecs[v].wdata, vecs[v].tx_data, vecs[v].empty});
            @(posedge clk); #1;
        end

        // Fill every region with transmitters held busy
        do_reset();
        apply_stimulus(4'hF, 32'hD3D2D1D0, 4'hF);
        reads = 0; writes = 0; exp_ch = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rx_read != 4'h0) begin
                exp_rd = 4'(1 << exp_ch);
                check_output("fill_order", rx_read, exp_rd);
                if (reads < 64) begin
                    check_output("fill_write", {we, addr, wdata},
                                 {1'b1, exp_ch[1:0], cnt[exp_ch][3:0], 8'(8'hD0 + exp_ch)});
                    cnt[exp_ch]++;
                end
                if (reads == 65) check_output("ovf_drop_ch1", we, 1'b0);
                reads++;
                exp_ch = (exp_ch + 1) % 4;
            end
            if (we) writes++;
            @(posedge clk); #1;
        end
        check_output("fill_writes", writes, 64);
        check_output("fill_empty", empty, 4'h0);
`ifdef UART_BUFFER_ROUTER_OVF_EN
        check_output("fill_reads", reads, 100);
        apply_stimulus(4'h0, 32'h0, 4'hF);
        @(negedge clk);
        check_output("ovf_set", ovf, 4'hF);
        @(posedge clk); #1;
        ovf_clr = 4'h2;
        @(posedge clk); #1;
        ovf_clr = 4'h0;
        @(negedge clk);
        check_output("ovf_clear", ovf, 4'hD);
`else
        check_output("fill_reads", reads, 64);
        apply_stimulus(4'h0, 32'h0, 4'hF);
        ovf_clr = 4'h2;
        @(negedge clk);
        check_output("ovf_off", ovf, 4'h0);
        @(posedge clk); #1;
        ovf_clr = 4'h0;
`endif

        // Stream 40 bytes through ch0 with a busy pattern on transmitter 0
        do_reset();
        sent = 0; got = 0; loads = 0; busy_cnt = 0;
        for (int c = 0; c < 2000 && got < 40; c++) begin
            apply_stimulus({3'b000, 1'(sent < 40)}, {24'h0, 8'(sent)}, {3'b000, 1'(busy_cnt > 0)});
            if (busy_cnt > 0) busy_cnt--;
            @(negedge clk);
            if (rx_read[0]) begin
                check_output("wrap_waddr", addr, {2'b00, 4'(sent)});
                sent++;
            end
            if (tx_write != 4'h0) begin
                check_output("wrap_tx", {tx_write, tx_data}, {4'h1, 8'(got)});
                got++;
                loads++;
                busy_cnt = (loads % 2 == 1) ? 1 : 5;
            end
            @(posedge clk); #1;
        end
        check_output("wrap_count", {sent[7:0], got[7:0]}, {8'd40, 8'd40});

        // Reset mid-stream with ch3 holding bytes and a transmit pending
        do_reset();
        apply_stimulus(4'h8, 32'h0, 4'h8);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            rx_data = {8'(8'h50 + n), 24'h0};
            @(negedge clk);
            if (rx_read[3]) n++;
            @(posedge clk); #1;
        end
        rx_ready = 4'h0;
        check_output("mid_filled", {n[3:0], empty}, {4'd5, 4'h7});
        for (int c = 0; c < 4 && tb_recv; c++) begin
            @(posedge clk); #1;
        end
        tx_busy = 4'h0;
        @(negedge clk);
        check_output("mid_read", {re, addr}, {1'b1, 6'h30});
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_empty", empty[3], 1'b1);
        check_output("mid_pend", tx_write, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        late_tx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_write[3]) late_tx++;
            @(posedge clk); #1;
        end
        check_output("mid_no_tx", late_tx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_buffer_router.md
# uart_buffer_router

Parametrised multi-channel UART store-and-forward router. It collects bytes from NCH UART receivers into per-channel circular regions of one shared single-port RAM and drains each region to the same-index UART transmitter. Arbitration is round-robin with explicit full/empty tracking. The block sits between the receiver/transmitter banks and the board RAM, replacing fixed-count collectors with a width-, depth- and channel-generic block.

## Interface

- NCH, 4, channel count (2..16); CW = $clog2(NCH)
- DW, 8, byte width
- AW_CH, 4, log2 of per-channel region depth (depth = 2^AW_CH)
- i_clk  in  1  sampling clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_rx_ready  in  NCH  receiver[i] holds a byte
- i_rx_data  in  NCH*DW  receiver[i] byte at bits [i*DW +: DW]
- o_rx_read  out  NCH  one-cycle pop pulse to receiver[i]
- i_tx_busy  in  NCH  transmitter[i] cannot accept a byte
- o_tx_write  out  NCH  one-cycle load pulse to transmitter[i]
- o_tx_data  out  DW  byte for the transmitter being loaded
- o_addr  out  CW+AW_CH  RAM address {channel, offset}
- o_wdata  out  DW  RAM write data
- i_rdata  in  DW  RAM read data, valid one cycle after o_re
- o_we  out  1  RAM write strobe
- o_re  out  1  RAM read strobe
- o_empty  out  NCH  region i holds no bytes
- o_ovf  out  NCH  sticky overflow flag (see Configuration)
- i_ovf_clr  in  NCH  clears o_ovf[i]

## Operation

- Per channel: wr_ptr and rd_ptr, AW_CH+1 bits each, wrapping mod 2^(AW_CH+1).
- Level is wr_ptr − rd_ptr. Empty when level is 0; full when level is 2^AW_CH.
- The FSM has two states, RECV and SEND. They strictly alternate every cycle, regardless of activity.
- RECV:
  - Eligible channel: i_rx_ready[i] and not full.
  - Grant the first eligible channel searching from rr_rx upward, modulo NCH.
  - On grant: o_rx_read[g]=1, o_we=1, o_addr={g, wr_ptr[g][AW_CH-1:0]}, o_wdata=i_rx_data[g].
  - At the edge: wr_ptr[g]++ and rr_rx=g+1 mod NCH.
  - No grant: rr_rx unchanged, all strobes 0.
- SEND:
  - Eligible channel: not empty and !i_tx_busy[i].
  - Grant the first eligible channel from rr_tx.
  - On grant: o_re=1, o_addr={g, rd_ptr[g][AW_CH-1:0]}.
  - At the edge: rd_ptr[g]++, rr_tx=g+1, pend_ch=g, pend_v=1.
- Following RECV cycle, if pend_v: o_tx_write[pend_ch]=1 and o_tx_data=i_rdata. pend_v then clears.
- At most one RAM access occurs per cycle, so a RAM port conflict is impossible.
- A byte written in RECV is readable in the very next SEND.
- Channel i's data goes only to transmitter i.

## Timing

- Reset (asynchronous, i_rst=0) puts the block in this state:
  - state=RECV
  - all pointers, rr_rx, rr_tx, pend_v set to 0
  - o_rx_read, o_tx_write, o_we, o_re all 0
  - o_addr, o_wdata, o_tx_data all 0
  - o_empty all 1, o_ovf all 0
- The first cycle after reset release is RECV.
- Reset mid-operation discards all buffered bytes and any pending transmit.
- Latency from receiver pop to transmitter load is a minimum of 2 cycles: RECV write, then SEND read, then RECV load.
- Per-channel throughput is at most one byte every 2 cycles. Aggregate throughput is 1 write plus 1 read per 2 cycles.
- o_empty is registered from the pointers and reflects the state after each edge.
- i_tx_busy must rise by the cycle after o_tx_write; the next SEND for that channel is at least 2 cycles later.
- i_ovf_clr and an overflow event in the same cycle leave o_ovf set (set wins).

## Configuration

- Macro: UART_BUFFER_ROUTER_OVF_EN.
- Defined:
  - In RECV, a full channel with i_rx_ready is also eligible.
  - When granted, the block pulses o_rx_read[g] and drops the byte: o_we=0, wr_ptr unchanged.
  - o_ovf[g] is set and stays set until i_ovf_clr[g].
- Undefined:
  - Full channels are ineligible, so the receiver backpressures.
  - o_ovf is tied to 0 and i_ovf_clr is ignored.

## Test plan

- Reset then idle: all outputs hold their reset values and o_empty=4'b1111. States alternate RECV/SEND.
- Single byte 8'hA5 on ch2, tx idle: RAM write at addr 6'h20. Read of 6'h20 in the next cycle. o_tx_write[2] with o_tx_data=8'hA5 2 cycles after o_rx_read[2].
- All 4 channels ready every cycle, tx held busy: RECV grants in order 0,1,2,3,0,… Each region fills to 16 bytes and o_empty clears. Then no further o_rx_read occurs (macro off).
- Same as the previous scenario with UART_BUFFER_ROUTER_OVF_EN defined: the 17th byte on ch1 is popped and not written, and o_ovf[1]=1. A pulse of i_ovf_clr[1] clears it.
- Wrap-around: stream 40 bytes 0..39 through ch0 with tx alternating busy. Transmitter receives 0..39 in order with no loss, and the offset wraps 15→0.
- Assert i_rst mid-stream with ch3 holding 5 bytes: o_empty[3]=1 immediately, and no o_tx_write[3] follows.
